// File: rtl/add_arb_seq.sv
// add_arb_seq: two-requester round-robin adder using one shared 8-bit slice, one byte per cycle
module add_arb_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_cin,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] res_sum,
  output logic                res_cout,
  output logic                res_id,
  output logic                busy
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state, state_nx;
  logic            ptr, g, acc, carry, last;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_r, b_r;
  logic [8:0]      slice;
  assign g          = req0_valid && req1_valid ? ptr : req1_valid;
  assign req0_ready = state == IDLE && !g;
  assign req1_ready = state == IDLE && g;
  assign acc        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign last       = idx == IW'(NBYTES - 1);
  assign slice      = {1'b0, a_r[8*idx +: 8]} + {1'b0, b_r[8*idx +: 8]} + {8'd0, carry};
  assign res_valid  = state == DONE;
  assign busy       = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (acc ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (res_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_id   <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        a_r    <= g ? req1_a : req0_a;
        b_r    <= g ? req1_b : req0_b;
        carry  <= g ? req1_cin : req0_cin;
        res_id <= g;
        idx    <= '0;
        ptr    <= !g;
      end else if (state == RUN) begin
        res_sum[8*idx +: 8] <= slice[7:0];
        carry               <= slice[8];
        idx                 <= idx + IW'(1);
        if (last) res_cout <= slice[8];
      end
    end
  end
endmodule

// File: tb/tb_add_arb_seq.sv
// tb_add_arb_seq: directed vectors for add_arb_seq
module tb_add_arb_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_cin = 1'b0, req1_cin = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        res_ready = 1'b1;
  logic        req0_ready, req1_ready, res_valid, res_cout, res_id, busy;
  logic [31:0] res_sum;
  int          checks = 0, errors = 0;
  add_arb_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_sum"}, res_sum, 0);
    chk({tag, "_cout"}, res_cout, 0);
    chk({tag, "_id"}, res_id, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic do_op(input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic c0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic c1,
                       input logic eid, input logic [31:0] esum, input logic ecout);
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    #1;
    chk("ready0", req0_ready, !eid);
    chk("ready1", req1_ready, eid);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hdeadbeef; req0_b = 32'hcafef00d; req1_a = 32'h5a5a5a5a; req1_b = 32'ha5a5a5a5;
    chk("busy_run", busy, 1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("valid_early", res_valid, 0);
    end
    @(posedge clk); #1;
    chk("valid_lat", res_valid, 1);
    chk("sum", res_sum, esum);
    chk("cout", res_cout, ecout);
    chk("id", res_id, eid);
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
  endtask
  initial begin
    #2;
    check_idle_zero("rst");
    @(negedge clk); rst_n = 1'b1;
    do_op(1, 0, 32'h000000ff, 32'h00000001, 0, 0, 0, 0, 0, 32'h00000100, 0);
    do_op(0, 1, 0, 0, 0, 32'hffffffff, 32'h00000000, 1, 1, 32'h00000000, 1);
    @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
    do_op(1, 1, 32'h1, 32'h2, 0, 32'd10, 32'd20, 0, 0, 32'd3, 0);
    do_op(1, 1, 32'h1, 32'h2, 0, 32'd10, 32'd20, 0, 1, 32'd30, 0);
    do_op(1, 1, 32'h1, 32'h2, 0, 32'd10, 32'd20, 0, 0, 32'd3, 0);
    @(negedge clk);
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h80000000; req0_b = 32'h80000000; req0_cin = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_sum", res_sum, 32'h0);
      chk("hold_cout", res_cout, 1);
      chk("hold_r0", req0_ready, 0);
      chk("hold_r1", req1_ready, 0);
      chk("hold_busy", busy, 1);
      @(posedge clk);
    end
    #1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_idle", busy, 0);
    chk("hs_valid", res_valid, 0);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h11111111; req0_b = 32'h22222222;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    check_idle_zero("abort");
    chk("abort_r0", req0_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_result", res_valid, 0);
    end
    do_op(0, 1, 0, 0, 0, 32'h12345678, 32'h11111111, 1, 1, 32'h2345678a, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add_arb_seq.md
ADD_ARB_SEQ -- requirements
Module: add_arb_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, number of 8-bit slices per operand (operand width W = 8*NBYTES).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 SHALL have ports req0_a, req0_b  input  W  requester 0 operands; req0_cin  input  1  requester 0 carry-in.
REQ-007 SHALL have ports req1_valid, req1_ready, req1_a, req1_b, req1_cin with identical widths and meaning for requester 1.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_sum  output  W  sum; res_cout  output  1  carry out of MSB; res_id  output  1  index of requester served.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL share one internal 8-bit full-adder slice (a+b+cin -> 8-bit sum, carry) across all byte positions and both requesters; no W-bit adder is permitted.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: grant = sole valid requester; if both valid, grant = requester indicated by round-robin pointer; reqN_ready = (state==IDLE) and grant==N, combinational; the non-granted ready is 0.
REQ-015 Acceptance occurs on an edge where reqN_valid and reqN_ready are both high: latch a, b, cin, res_id=N, byte index=0, carry=cin; go to RUN; pointer set to the other requester.
REQ-016 A requester deasserting valid before acceptance SHALL have no effect on state or pointer.
REQ-017 RUN: each cycle adds byte[idx] of a and b with carry, writes result into res_sum[8*idx+7:8*idx], updates carry, increments idx; after idx==NBYTES-1 go to DONE, res_cout = final carry.
REQ-018 Latency: res_valid SHALL rise exactly NBYTES cycles after the accepting edge (4 cycles for NBYTES=4).
REQ-019 Arithmetic is modulo 2^W; carry SHALL propagate across all slice boundaries exactly as a W-bit ripple adder.
REQ-020 DONE: res_valid=1; res_sum, res_cout, res_id held stable until res_valid and res_ready both high on an edge, then go to IDLE.
REQ-021 Both reqN_ready SHALL be 0 in RUN and DONE; no acceptance on the result-handshake edge; earliest next acceptance is the following cycle.
REQ-022 res_sum bytes not yet computed in RUN are don't-care internally but SHALL not be observable (res_valid=0 in RUN).
REQ-023 Operand inputs changing after acceptance SHALL not affect the in-flight result.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, idx=0, carry=0, pointer=requester 0.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no result produced; after release the block is in IDLE with requester 0 preferred.

Verification
REQ-026 req0 a=0x000000FF b=0x00000001 cin=0 -> res_valid 4 cycles after accept, res_sum=0x00000100, res_cout=0, res_id=0.
REQ-027 req1 a=0xFFFFFFFF b=0x00000000 cin=1 -> res_sum=0x00000000, res_cout=1, res_id=1 (full carry ripple).
REQ-028 After reset, req0 and req1 valid same cycle, res_ready=1 -> req0 served first, req1 next; re-issue both -> req0 served (pointer alternates).
REQ-029 a=0x80000000 b=0x80000000 cin=0, res_ready low 10 cycles -> res_valid and res_sum=0x00000000, res_cout=1 held 10 cycles, both ready=0, busy=1; completes on res_ready.
REQ-030 rst_n pulsed low mid-RUN -> all outputs 0 immediately, no res_valid afterwards; next req1-only operation is accepted and completes correctly.
